// File: rtl/branch_pkg.sv
// Shared branch opcodes, funct3 encodings and BrOp decode masks.
package branch_pkg;

   localparam logic [4:0] BR_BEQ  = 5'b01000;
   localparam logic [4:0] BR_BNE  = 5'b01001;
   localparam logic [4:0] BR_BLT  = 5'b01100;
   localparam logic [4:0] BR_BGE  = 5'b01101;
   localparam logic [4:0] BR_BLTU = 5'b01110;
   localparam logic [4:0] BR_BGEU = 5'b01111;
   localparam logic [4:0] BR_JAL  = 5'b11010;
   localparam logic [4:0] BR_JALR = 5'b10001;

   // BrOp[4] marks any jump; BrOp[4:3]==01 marks a conditional branch.
   localparam logic [4:0] BR_JUMP_MASK  = 5'b10000;
   localparam logic [4:0] BR_CLASS_MASK = 5'b11000;
   localparam logic [4:0] BR_COND_CLASS = 5'b01000;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } funct3_e;

endpackage

// File: rtl/branch_unit_if.sv
// Operand/opcode bundle into the branch unit and its decision/statistics outputs.
interface branch_unit_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [4:0]       BrOp;
   logic             instr_valid;
   logic             NextPCSrc;
   logic             taken_q;
   logic [CNT_W-1:0] cnt_cond;
   logic [CNT_W-1:0] cnt_taken;
   logic [CNT_W-1:0] cnt_jump;

   modport master (
      output rs1, rs2, BrOp, instr_valid,
      input  NextPCSrc, taken_q, cnt_cond, cnt_taken, cnt_jump
   );

   modport slave (
      input  rs1, rs2, BrOp, instr_valid,
      output NextPCSrc, taken_q, cnt_cond, cnt_taken, cnt_jump
   );
endinterface

// File: rtl/branch_compare.sv
// Combinational operand comparator: equality, signed less-than, unsigned less-than.
module branch_compare #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            eq_o,
   output logic            lt_s_o,
   output logic            lt_u_o
);

   assign eq_o   = (rs1_i == rs2_i);
   assign lt_s_o = ($signed(rs1_i) < $signed(rs2_i));
   assign lt_u_o = (rs1_i < rs2_i);

endmodule

// File: rtl/branch_unit.sv
// Branch decision (zero-latency NextPCSrc) plus saturating branch statistics.
// taken_q and counters update one edge after a valid instruction; async reset clears them.
module branch_unit
   import branch_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   branch_unit_if.slave bus
);

   logic             eq, lt_s, lt_u;
   logic             take, cond_vld, is_jump;
   logic             taken_d, taken_q;
   logic [CNT_W-1:0] cnt_cond_d, cnt_cond_q;
   logic [CNT_W-1:0] cnt_taken_d, cnt_taken_q;
   logic [CNT_W-1:0] cnt_jump_d, cnt_jump_q;

   branch_compare #(.XLEN(XLEN)) u_cmp (
      .rs1_i  (bus.rs1),
      .rs2_i  (bus.rs2),
      .eq_o   (eq),
      .lt_s_o (lt_s),
      .lt_u_o (lt_u)
   );

   always_comb begin
      take     = 1'b0;
      cond_vld = 1'b0;
      is_jump  = ((bus.BrOp & BR_JUMP_MASK) != 5'b0);
      if (is_jump) begin
         take = 1'b1;
      end else if ((bus.BrOp & BR_CLASS_MASK) == BR_COND_CLASS) begin
         cond_vld = 1'b1;
         case (bus.BrOp[2:0])
            F3_BEQ:  take = eq;
            F3_BNE:  take = ~eq;
            F3_BLT:  take = lt_s;
            F3_BGE:  take = ~lt_s;
            F3_BLTU: take = lt_u;
            F3_BGEU: take = ~lt_u;
            default: cond_vld = 1'b0;
         endcase
      end
   end

   assign bus.NextPCSrc = take;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      taken_d     = taken_q;
      cnt_cond_d  = cnt_cond_q;
      cnt_taken_d = cnt_taken_q;
      cnt_jump_d  = cnt_jump_q;
      if (bus.instr_valid) begin
         taken_d = take;
         if (cond_vld && (cnt_cond_q != '1))
            cnt_cond_d = cnt_cond_q + CNT_W'(1);
         if (cond_vld && take && (cnt_taken_q != '1))
            cnt_taken_d = cnt_taken_q + CNT_W'(1);
         if (is_jump && (cnt_jump_q != '1))
            cnt_jump_d = cnt_jump_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q     <= 1'b0;
         cnt_cond_q  <= '0;
         cnt_taken_q <= '0;
         cnt_jump_q  <= '0;
      end else begin
         taken_q     <= taken_d;
         cnt_cond_q  <= cnt_cond_d;
         cnt_taken_q <= cnt_taken_d;
         cnt_jump_q  <= cnt_jump_d;
      end
   end

   assign bus.taken_q   = taken_q;
   assign bus.cnt_cond  = cnt_cond_q;
   assign bus.cnt_taken = cnt_taken_q;
   assign bus.cnt_jump  = cnt_jump_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: decision table, counters, reset and saturation.
module tb_branch_unit;

   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   branch_unit_if #(.XLEN(32), .CNT_W(32)) bus ();
   branch_unit_if #(.XLEN(32), .CNT_W(4))  bus4 ();

   branch_unit #(.XLEN(32), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   branch_unit #(.XLEN(32), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        exp;
   } vec_t;

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic vld);
      bus.BrOp        = op;
      bus.rs1         = a;
      bus.rs2         = b;
      bus.instr_valid = vld;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(5'b01000, 32'd8, 32'd8, 1'b1);
      bus4.BrOp = 5'b00000; bus4.rs1 = '0; bus4.rs2 = '0; bus4.instr_valid = 1'b0;
      #1;
      vec_cnt++;
      if ({bus.taken_q, bus.cnt_cond, bus.cnt_taken, bus.cnt_jump} !== 97'd0) begin
         err_cnt++;
         $display("FAIL reset_state: got tq=%b c=%0d t=%0d j=%0d, want all 0",
                  bus.taken_q, bus.cnt_cond, bus.cnt_taken, bus.cnt_jump);
      end
      vec_cnt++;
      if (bus.NextPCSrc !== 1'b1) begin
         err_cnt++;
         $display("FAIL decide_in_reset: got %b want 1", bus.NextPCSrc);
      end
      repeat (2) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus.cnt_cond !== 32'd0) begin
         err_cnt++;
         $display("FAIL reset_hold: cnt_cond=%0d want 0", bus.cnt_cond);
      end
      @(negedge clk);
      drive(5'b00000, 32'd0, 32'd0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic run_table(input string name, input vec_t tbl[]);
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
         #1;
         vec_cnt++;
         if (bus.NextPCSrc !== tbl[i].exp) begin
            err_cnt++;
            $display("FAIL %s[%0d]: op=%b rs1=%h rs2=%h got %b want %b",
                     name, i, tbl[i].op, tbl[i].a, tbl[i].b, bus.NextPCSrc, tbl[i].exp);
         end
      end
   endtask

   task automatic test_beq_bne();
      vec_t t[] = '{
         '{5'b01000, 32'd4,  32'd8,  1'b0},
         '{5'b01000, 32'd8,  32'd8,  1'b1},
         '{5'b01001, 32'd12, 32'd8,  1'b1},
         '{5'b01001, 32'd16, 32'd16, 1'b0}
      };
      run_table("beq_bne", t);
   endtask

   task automatic test_blt_bge();
      vec_t t[] = '{
         '{5'b01100, 32'hFFFF_FFFC, 32'd8,          1'b1},
         '{5'b01100, 32'd16,        32'hFFFF_FFFC,  1'b0},
         '{5'b01101, 32'd4,         32'd8,          1'b0},
         '{5'b01101, 32'd8,         32'd8,          1'b1},
         '{5'b01101, 32'd12,        32'd8,          1'b1},
         '{5'b01100, 32'h7FFF_FFFF, 32'h8000_0000,  1'b0}
      };
      run_table("blt_bge", t);
   endtask

   task automatic test_bltu_bgeu();
      vec_t t[] = '{
         '{5'b01110, 32'hFFFF_FFF4, 32'd8,          1'b0},
         '{5'b01110, 32'hFFFF_FFFC, 32'd4,          1'b0},
         '{5'b01110, 32'd4,         32'hFFFF_FFF0,  1'b1},
         '{5'b01111, 32'd4,         32'hFFFF_FFF8,  1'b0},
         '{5'b01111, 32'hFFFF_FFF8, 32'd8,          1'b1},
         '{5'b01111, 32'hFFFF_FFF4, 32'd8,          1'b1}
      };
      run_table("bltu_bgeu", t);
   endtask

   task automatic test_jump_nonbranch();
      vec_t t[] = '{
         '{5'b11010, 32'hFFFF_FFF4, 32'd8, 1'b1},
         '{5'b10001, 32'hFFFF_FFF4, 32'd8, 1'b1},
         '{5'b11111, 32'd0,         32'd0, 1'b1},
         '{5'b01010, 32'd8,         32'd8, 1'b0},
         '{5'b01011, 32'd4,         32'd8, 1'b0},
         '{5'b00000, 32'd8,         32'd8, 1'b0},
         '{5'b00111, 32'd4,         32'd8, 1'b0}
      };
      run_table("jump_nonbr", t);
   endtask

   task automatic test_counters();
      vec_t seq[] = '{
         '{5'b01000, 32'd8,  32'd8,  1'b1},
         '{5'b01001, 32'd16, 32'd16, 1'b0},
         '{5'b11010, 32'd0,  32'd0,  1'b1},
         '{5'b01010, 32'd8,  32'd8,  1'b0}
      };
      // Build up some nonzero state first so the mid-run reset is visible.
      @(negedge clk);
      drive(5'b11010, 32'd0, 32'd0, 1'b1);
      repeat (3) @(negedge clk);
      drive(5'b01000, 32'd8, 32'd8, 1'b1);
      @(posedge clk);
      #2;
      vec_cnt++;
      if (bus.cnt_jump !== 32'd3 || bus.cnt_taken !== 32'd1 || bus.taken_q !== 1'b1) begin
         err_cnt++;
         $display("FAIL pre_reset: j=%0d t=%0d tq=%b want 3 1 1",
                  bus.cnt_jump, bus.cnt_taken, bus.taken_q);
      end
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if ({bus.taken_q, bus.cnt_cond, bus.cnt_taken, bus.cnt_jump} !== 97'd0) begin
         err_cnt++;
         $display("FAIL async_reset: tq=%b c=%0d t=%0d j=%0d want all 0",
                  bus.taken_q, bus.cnt_cond, bus.cnt_taken, bus.cnt_jump);
      end
      @(negedge clk);
      drive(seq[0].op, seq[0].a, seq[0].b, 1'b1);
      rst_n = 1'b1;
      foreach (seq[i]) begin
         if (i > 0) begin
            @(negedge clk);
            drive(seq[i].op, seq[i].a, seq[i].b, 1'b1);
         end
         @(posedge clk);
         #1;
         vec_cnt++;
         if (bus.taken_q !== seq[i].exp) begin
            err_cnt++;
            $display("FAIL taken_q[%0d]: got %b want %b", i, bus.taken_q, seq[i].exp);
         end
      end
      vec_cnt++;
      if (bus.cnt_cond !== 32'd2 || bus.cnt_taken !== 32'd1 || bus.cnt_jump !== 32'd1) begin
         err_cnt++;
         $display("FAIL counts: c=%0d t=%0d j=%0d want 2 1 1",
                  bus.cnt_cond, bus.cnt_taken, bus.cnt_jump);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      drive(5'b11010, 32'd0, 32'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus.cnt_cond !== 32'd2 || bus.cnt_taken !== 32'd1 || bus.cnt_jump !== 32'd1 ||
          bus.taken_q !== 1'b0) begin
         err_cnt++;
         $display("FAIL hold_invalid: c=%0d t=%0d j=%0d tq=%b want 2 1 1 0",
                  bus.cnt_cond, bus.cnt_taken, bus.cnt_jump, bus.taken_q);
      end
   endtask

   task automatic test_saturation();
      @(negedge clk);
      bus4.BrOp = 5'b10001; bus4.rs1 = 32'hFFFF_FFF4; bus4.rs2 = 32'd8;
      bus4.instr_valid = 1'b1;
      repeat (14) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus4.cnt_jump !== 4'd14) begin
         err_cnt++;
         $display("FAIL sat_pre: cnt_jump=%0d want 14", bus4.cnt_jump);
      end
      repeat (6) @(posedge clk);
      #1;
      vec_cnt++;
      if (bus4.cnt_jump !== 4'd15 || bus4.cnt_cond !== 4'd0 || bus4.cnt_taken !== 4'd0) begin
         err_cnt++;
         $display("FAIL sat_hold: j=%0d c=%0d t=%0d want 15 0 0",
                  bus4.cnt_jump, bus4.cnt_cond, bus4.cnt_taken);
      end
      @(negedge clk);
      bus4.instr_valid = 1'b0;
   endtask

   initial begin
      vec_cnt = 0;
      err_cnt = 0;
      test_reset();
      test_beq_bne();
      test_blt_bge();
      test_bltu_bgeu();
      test_jump_nonbranch();
      test_counters();
      test_hold();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch-decision block for the single-cycle RV32I datapath. It compares the two register operands, rs1 and rs2, under a 5-bit branch opcode from the control unit. It drives NextPCSrc combinationally, in the same cycle, to the next-PC mux: 1 selects the branch/jump target, 0 selects PC+4. It also keeps clocked branch statistics for debug and performance readout.

## Interface
Parameters:
- XLEN, default 32: operand width.
- CNT_W, default 32: statistics counter width.

Ports:
- clk  in  1: single system clock; only the statistics registers use it.
- rst_n  in  1: asynchronous, active-low reset.
- rs1  in  XLEN: operand 1, two's complement.
- rs2  in  XLEN: operand 2, two's complement.
- BrOp  in  5: branch opcode from the control unit.
- instr_valid  in  1: the current instruction retires this cycle; qualifies the counters only.
- NextPCSrc  out  1: 1 means take the target, 0 means PC+4.
- taken_q  out  1: registered NextPCSrc of the last valid instruction.
- cnt_cond  out  CNT_W: count of conditional branches executed.
- cnt_taken  out  CNT_W: count of conditional branches taken.
- cnt_jump  out  CNT_W: count of unconditional jumps.

## Operation
- BrOp[4]=1: unconditional jump (jal 11010, jalr 10001, any 1xxxx). NextPCSrc=1.
- BrOp[4:3]=00: not a control-flow instruction. NextPCSrc=0.
- BrOp[4:3]=01: conditional branch; BrOp[2:0] is funct3.
  - 000 beq: rs1==rs2.
  - 001 bne: rs1!=rs2.
  - 100 blt: signed rs1<rs2.
  - 101 bge: signed rs1>=rs2.
  - 110 bltu: unsigned rs1<rs2.
  - 111 bgeu: unsigned rs1>=rs2.
  - 010 and 011 are reserved and give NextPCSrc=0.
- Signed compares treat bit XLEN-1 as the sign bit. Unsigned compares treat both operands as 0..2^XLEN-1.
- NextPCSrc is purely combinational from rs1, rs2 and BrOp. It is independent of clk, rst_n and instr_valid, and is never X when its inputs are known.
- Counter updates on a rising clk edge, only when instr_valid=1:
  - BrOp[4:3]=01 with a defined funct3: cnt_cond += 1.
  - The same case with NextPCSrc=1: cnt_taken += 1 as well.
  - BrOp[4]=1: cnt_jump += 1.
  - taken_q <= NextPCSrc.
- Counters saturate at all-ones and do not wrap.
- Reserved funct3 codes and BrOp[4:3]=00 update taken_q only.

## Timing
- NextPCSrc has zero latency: it settles in the same cycle as the inputs, with no registers on the path.
- taken_q and the counters have 1-cycle latency after the qualifying edge.
- rst_n low, asynchronously: taken_q=0 and all counters=0 immediately, with no clk needed. NextPCSrc keeps operating during reset.
- Reset deasserted while instr_valid=1: the first edge after release counts normally.
- instr_valid=0: all registers hold.
- A counter at saturation stays at all-ones while further events occur.

## Structure
- Package branch_pkg holds:
  - the BrOp localparams (BR_BEQ=01000, BR_BNE=01001, BR_BLT=01100, BR_BGE=01101, BR_BLTU=01110, BR_BGEU=01111, BR_JAL=11010, BR_JALR=10001);
  - the funct3 enum and the mask constants for BrOp[4] and BrOp[4:3].
- One sub-module, branch_compare. It is combinational and outputs eq, lt_s and lt_u from rs1 and rs2.
- The top level holds the decode mux, the counters and taken_q.

## Test plan
- beq:
  - rs1=4, rs2=8, BrOp=01000 -> NextPCSrc=0.
  - rs1=8, rs2=8 -> NextPCSrc=1.
- bne, BrOp=01001:
  - rs1=12, rs2=8 -> 1.
  - rs1=16, rs2=16 -> 0.
- blt, BrOp=01100, and bge, BrOp=01101:
  - blt -4<8 -> 1; blt 16<-4 -> 0.
  - bge 4>=8 -> 0; bge 8>=8 -> 1; bge 12>=8 -> 1.
- bltu, BrOp=01110, and bgeu, BrOp=01111:
  - bltu -12<8 -> 0; bltu -4<4 -> 0; bltu 4<-16 -> 1.
  - bgeu 4>=-8 -> 0; bgeu -8>=8 -> 1; bgeu -12>=8 -> 1.
- Jumps and non-branches:
  - BrOp=11010 (jal) or 10001 (jalr) with rs1=-12, rs2=8 -> 1.
  - BrOp=01010, 01011 or 00000 -> 0.
- Counters:
  - rst_n low mid-run -> counters and taken_q read 0 at once, with no clock edge.
  - Then on 4 valid edges (beq taken, bne not taken, jal, reserved 01010) -> cnt_cond=2, cnt_taken=1, cnt_jump=1, taken_q=0.
  - Edges with instr_valid=0 -> no change.
  - Preset near saturation (CNT_W=4) and drive 20 jumps -> cnt_jump holds at 15.
